// File: rtl/tps_pkg.sv
// Shared types and constants for the trade pipeline scheduler.
package tps_pkg;

  typedef enum logic [1:0] {
    TPS_IDLE  = 2'd0,
    TPS_RUN   = 2'd1,
    TPS_DRAIN = 2'd2
  } tps_state_e;

  localparam logic [31:0] Q16_ONE = 32'h0001_0000;

endpackage

// File: rtl/tps_tag_fifo.sv
// In-order source-tag FIFO; head is valid whenever o_empty is low.
// Push while full and pop while empty are ignored; full does not consider a same-cycle pop.
module tps_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointers wrap naturally; occupancy kept separately so full/empty are unambiguous.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/trade_pipe_sched.sv
// Round-robin share of one trading pipeline between NUM_SRC feeds, results tagged by source.
// Optional per-source grant counters under `TPS_PERF_CNT_EN; otherwise cnt_value is tied to 0.
module trade_pipe_sched
  import tps_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int DATA_W       = 32,
  parameter int MAX_INFLIGHT = 8,
  parameter int SRC_W        = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      pipe_in_valid,
  input  logic                      pipe_in_ready,
  output logic [DATA_W-1:0]         pipe_in_data,
  input  logic                      pipe_out_valid,
  output logic                      pipe_out_ready,
  input  logic [DATA_W-1:0]         pipe_out_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_W-1:0]         res_data,
  output logic [SRC_W-1:0]          res_src,
  output logic                      busy,
  output logic                      err_orphan,
  input  logic [SRC_W-1:0]          cnt_sel,
  output logic [31:0]               cnt_value
);
  tps_state_e       r_state;
  logic [SRC_W-1:0] r_rr_ptr;
  logic [SRC_W-1:0] w_gnt_idx;
  logic             w_any;
  logic             w_adm;
  logic             w_push;
  logic             w_out_hs;
  logic             w_full;
  logic             w_empty;
  logic [SRC_W-1:0] w_head;

  // First valid source at or after the priority pointer, modulo NUM_SRC.
  always_comb begin
    int               v;
    logic [SRC_W-1:0] idx;
    v         = 0;
    idx       = '0;
    w_any     = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      v = int'(r_rr_ptr) + k;
      if (v >= NUM_SRC) v = v - NUM_SRC;
      idx = SRC_W'(v);
      if (!w_any && src_valid[idx]) begin
        w_any     = 1'b1;
        w_gnt_idx = idx;
      end
    end
  end

  assign w_adm          = (r_state == TPS_RUN) && !w_full;
  assign pipe_in_valid  = w_adm && w_any;
  assign pipe_in_data   = src_data[w_gnt_idx*DATA_W +: DATA_W];
  assign src_ready      = (pipe_in_valid && pipe_in_ready) ? (NUM_SRC'(1) << w_gnt_idx) : '0;
  assign w_push         = pipe_in_valid && pipe_in_ready;
  assign pipe_out_ready = !res_valid || res_ready;
  assign w_out_hs       = pipe_out_valid && pipe_out_ready;
  assign busy           = (r_state != TPS_IDLE) || !w_empty;

  tps_tag_fifo #(
    .WIDTH (SRC_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_gnt_idx),
    .i_pop      (w_out_hs),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head     (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= TPS_IDLE;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        TPS_IDLE:  if (enable) r_state <= TPS_RUN;
        TPS_RUN:   if (!enable) r_state <= TPS_DRAIN;
        TPS_DRAIN: begin
          if (enable)                     r_state <= TPS_RUN;
          else if (w_empty && !res_valid) r_state <= TPS_IDLE;
        end
        default:   r_state <= TPS_IDLE;
      endcase
      if (w_push)
        r_rr_ptr <= (w_gnt_idx == SRC_W'(NUM_SRC-1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // A result with no outstanding tag is still delivered, tagged as source 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_src    <= '0;
      err_orphan <= 1'b0;
    end else if (w_out_hs) begin
      res_valid <= 1'b1;
      res_data  <= pipe_out_data;
      if (w_empty) begin
        res_src    <= '0;
        err_orphan <= 1'b1;
      end else begin
        res_src <= w_head;
      end
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef TPS_PERF_CNT_EN
  logic [31:0] r_cnt [NUM_SRC];
  logic [31:0] r_cnt_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) r_cnt[i] <= '0;
      r_cnt_value <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++)
        if (w_push && (w_gnt_idx == SRC_W'(i)) && (r_cnt[i] != 32'hFFFF_FFFF))
          r_cnt[i] <= r_cnt[i] + 32'd1;
      r_cnt_value <= (int'(cnt_sel) < NUM_SRC) ? r_cnt[cnt_sel] : '0;
    end
  end

  assign cnt_value = r_cnt_value;
`else
  logic w_unused_cnt_sel;
  assign w_unused_cnt_sel = ^cnt_sel;
  assign cnt_value        = '0;
`endif

endmodule

// File: tb/tb_trade_pipe_sched.sv
// Directed bench for trade_pipe_sched: reset, fairness, sparse round-robin, full FIFO,
// drain, orphan result, result backpressure and grant counters.
module tb_trade_pipe_sched;
  import tps_pkg::*;

  logic         clk = 1'b0;
  logic         rst, enable;
  logic [3:0]   src_valid, src_ready;
  logic [127:0] src_data;
  logic         pipe_in_valid, pipe_in_ready;
  logic [31:0]  pipe_in_data;
  logic         pipe_out_valid, pipe_out_ready;
  logic [31:0]  pipe_out_data;
  logic         res_valid, res_ready;
  logic [31:0]  res_data;
  logic [1:0]   res_src;
  logic         busy, err_orphan;
  logic [1:0]   cnt_sel;
  logic [31:0]  cnt_value;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] sp_vld [8];
  logic [3:0] sp_exp [8];

  trade_pipe_sched #(.NUM_SRC(4), .DATA_W(32), .MAX_INFLIGHT(8)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .pipe_in_valid(pipe_in_valid), .pipe_in_ready(pipe_in_ready), .pipe_in_data(pipe_in_data),
    .pipe_out_valid(pipe_out_valid), .pipe_out_ready(pipe_out_ready), .pipe_out_data(pipe_out_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_src(res_src),
    .busy(busy), .err_orphan(err_orphan), .cnt_sel(cnt_sel), .cnt_value(cnt_value)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; src_valid = '0; pipe_in_ready = 1'b0;
    pipe_out_valid = 1'b0; pipe_out_data = '0; res_ready = 1'b1; cnt_sel = '0;
    for (int i = 0; i < 4; i++) src_data[i*32 +: 32] = Q16_ONE * (i + 1);
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; src_valid = 4'hF; pipe_in_ready = 1'b1;
    pipe_out_valid = 1'b0; pipe_out_data = '0; res_ready = 1'b1; cnt_sel = 2'd0;
    src_data = '0;
    tick(); tick(); #1;
    n_cmp++; if (src_ready !== 4'h0) begin n_err++; $display("FAIL rst_src_ready: got %h want 0", src_ready); end
    n_cmp++; if (pipe_in_valid !== 1'b0) begin n_err++; $display("FAIL rst_pipe_in_valid: got %b want 0", pipe_in_valid); end
    n_cmp++; if (pipe_out_ready !== 1'b1) begin n_err++; $display("FAIL rst_pipe_out_ready: got %b want 1", pipe_out_ready); end
    n_cmp++; if (res_valid !== 1'b0 || res_data !== 32'h0 || res_src !== 2'd0)
      begin n_err++; $display("FAIL rst_res: got v=%b d=%h s=%0d want 0/0/0", res_valid, res_data, res_src); end
    n_cmp++; if (busy !== 1'b0 || err_orphan !== 1'b0)
      begin n_err++; $display("FAIL rst_flags: got busy=%b err=%b want 0/0", busy, err_orphan); end
    n_cmp++; if (cnt_value !== 32'h0) begin n_err++; $display("FAIL rst_cnt: got %h want 0", cnt_value); end
    rst = 1'b0;
    tick(); #1;
    n_cmp++; if (pipe_in_valid !== 1'b0) begin n_err++; $display("FAIL idle_no_admit: got %b want 0", pipe_in_valid); end
    enable = 1'b1; #1;
    n_cmp++; if (pipe_in_valid !== 1'b0) begin n_err++; $display("FAIL idle_enable_same_cycle: got %b want 0", pipe_in_valid); end
    tick(); #1;
    n_cmp++; if (pipe_in_valid !== 1'b1 || src_ready !== 4'b0001)
      begin n_err++; $display("FAIL run_first_grant: got v=%b rdy=%h want 1/1", pipe_in_valid, src_ready); end
  endtask

  task automatic test_fairness();
    do_reset();
    enable = 1'b1; tick();
    src_valid = 4'hF; pipe_in_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++; if (src_ready !== (4'b0001 << (k % 4)))
        begin n_err++; $display("FAIL fair_grant[%0d]: got %h want %h", k, src_ready, 4'b0001 << (k % 4)); end
      n_cmp++; if (pipe_in_data !== Q16_ONE * ((k % 4) + 1))
        begin n_err++; $display("FAIL fair_data[%0d]: got %h want %h", k, pipe_in_data, Q16_ONE * ((k % 4) + 1)); end
      tick();
    end
    pipe_in_ready = 1'b0; #1;
    n_cmp++; if (src_ready !== 4'h0 || pipe_in_valid !== 1'b1)
      begin n_err++; $display("FAIL fair_stall: got rdy=%h v=%b want 0/1", src_ready, pipe_in_valid); end
    for (int k = 0; k < 6; k++) begin
      pipe_out_valid = 1'b1; pipe_out_data = 32'hA000_0000 + k;
      tick();
      n_cmp++; if (res_valid !== 1'b1 || res_src !== 2'(k % 4) || res_data !== 32'hA000_0000 + k)
        begin n_err++; $display("FAIL fair_res[%0d]: got v=%b s=%0d d=%h want 1/%0d/%h", k, res_valid, res_src, res_data, k % 4, 32'hA000_0000 + k); end
    end
    pipe_out_valid = 1'b0; tick();
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL fair_res_clear: got %b want 0", res_valid); end
  endtask

  task automatic test_sparse();
    sp_vld = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0111, 4'b0111, 4'b0111, 4'b0111};
    sp_exp = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0001};
    do_reset();
    enable = 1'b1; tick();
    pipe_in_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      src_valid = sp_vld[k]; #1;
      n_cmp++; if (src_ready !== sp_exp[k])
        begin n_err++; $display("FAIL sparse_grant[%0d]: got %h want %h", k, src_ready, sp_exp[k]); end
      tick();
    end
  endtask

  task automatic test_full();
    int hs;
    do_reset();
    enable = 1'b1; tick();
    src_valid = 4'hF; pipe_in_ready = 1'b1; hs = 0;
    for (int k = 0; k < 12; k++) begin
      #1; if (pipe_in_valid && pipe_in_ready) hs++;
      tick();
    end
    n_cmp++; if (hs !== 8) begin n_err++; $display("FAIL full_count: got %0d handshakes want 8", hs); end
    #1;
    n_cmp++; if (pipe_in_valid !== 1'b0 || busy !== 1'b1)
      begin n_err++; $display("FAIL full_block: got v=%b busy=%b want 0/1", pipe_in_valid, busy); end
    pipe_out_valid = 1'b1; pipe_out_data = 32'h5555_0000; #1;
    n_cmp++; if (pipe_in_valid !== 1'b0) begin n_err++; $display("FAIL full_same_cycle_pop: got %b want 0", pipe_in_valid); end
    tick();
    pipe_out_valid = 1'b0;
    n_cmp++; if (res_valid !== 1'b1 || res_src !== 2'd0)
      begin n_err++; $display("FAIL full_release_res: got v=%b s=%0d want 1/0", res_valid, res_src); end
    hs = 0;
    for (int k = 0; k < 5; k++) begin
      #1; if (pipe_in_valid && pipe_in_ready) hs++;
      tick();
    end
    n_cmp++; if (hs !== 1) begin n_err++; $display("FAIL full_one_more: got %0d handshakes want 1", hs); end
  endtask

  task automatic test_drain();
    int w;
    do_reset();
    enable = 1'b1; tick();
    src_valid = 4'hF; pipe_in_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) enable = 1'b0;
      #1;
      n_cmp++; if (src_ready !== (4'b0001 << k))
        begin n_err++; $display("FAIL drain_grant[%0d]: got %h want %h", k, src_ready, 4'b0001 << k); end
      tick();
    end
    #1;
    n_cmp++; if (src_ready !== 4'h0 || pipe_in_valid !== 1'b0 || busy !== 1'b1)
      begin n_err++; $display("FAIL drain_stop: got rdy=%h v=%b busy=%b want 0/0/1", src_ready, pipe_in_valid, busy); end
    for (int k = 0; k < 3; k++) begin
      pipe_out_valid = 1'b1; pipe_out_data = 32'hD000_0000 + k; #1;
      n_cmp++; if (src_ready !== 4'h0) begin n_err++; $display("FAIL drain_no_ready[%0d]: got %h want 0", k, src_ready); end
      tick();
      n_cmp++; if (res_src !== 2'(k) || res_data !== 32'hD000_0000 + k)
        begin n_err++; $display("FAIL drain_res[%0d]: got s=%0d d=%h want %0d/%h", k, res_src, res_data, k, 32'hD000_0000 + k); end
    end
    pipe_out_valid = 1'b0;
    w = 0;
    while (busy !== 1'b0 && w < 10) begin tick(); w++; end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drain_idle: busy=%b after %0d cycles want 0", busy, w); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL drain_res_clear: got %b want 0", res_valid); end
  endtask

  task automatic test_orphan();
    do_reset();
    pipe_out_valid = 1'b1; pipe_out_data = 32'h0BAD_0001; #1;
    n_cmp++; if (pipe_out_ready !== 1'b1) begin n_err++; $display("FAIL orphan_ready: got %b want 1", pipe_out_ready); end
    tick();
    pipe_out_valid = 1'b0;
    n_cmp++; if (err_orphan !== 1'b1 || res_src !== 2'd0 || res_valid !== 1'b1 || res_data !== 32'h0BAD_0001)
      begin n_err++; $display("FAIL orphan_flag: got err=%b s=%0d v=%b d=%h want 1/0/1/0bad0001", err_orphan, res_src, res_valid, res_data); end
    tick(); tick(); tick();
    n_cmp++; if (err_orphan !== 1'b1) begin n_err++; $display("FAIL orphan_sticky: got %b want 1", err_orphan); end
    do_reset();
    n_cmp++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL orphan_clear: got %b want 0", err_orphan); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_cnt;
`ifdef TPS_PERF_CNT_EN
    exp_cnt = 32'd5;
`else
    exp_cnt = 32'd0;
`endif
    do_reset();
    enable = 1'b1; tick();
    src_valid = 4'b0100; src_data[2*32 +: 32] = 32'h0003_8000; pipe_in_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (src_ready !== 4'b0100 || pipe_in_data !== 32'h0003_8000)
        begin n_err++; $display("FAIL bp_grant2[%0d]: got rdy=%h d=%h want 4/00038000", k, src_ready, pipe_in_data); end
      tick();
    end
    src_valid = 4'h0; #1;
    n_cmp++; if (pipe_in_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_src: got %b want 0", pipe_in_valid); end
    res_ready = 1'b0; pipe_out_valid = 1'b1; pipe_out_data = 32'h1111_0000;
    tick();
    pipe_out_data = 32'h2222_0000; #1;
    n_cmp++; if (res_valid !== 1'b1 || res_src !== 2'd2 || pipe_out_ready !== 1'b0)
      begin n_err++; $display("FAIL bp_hold: got v=%b s=%0d ordy=%b want 1/2/0", res_valid, res_src, pipe_out_ready); end
    tick();
    n_cmp++; if (res_data !== 32'h1111_0000) begin n_err++; $display("FAIL bp_stable: got %h want 11110000", res_data); end
    res_ready = 1'b1; #1;
    n_cmp++; if (pipe_out_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got %b want 1", pipe_out_ready); end
    tick();
    pipe_out_valid = 1'b0;
    n_cmp++; if (res_data !== 32'h2222_0000 || res_src !== 2'd2)
      begin n_err++; $display("FAIL bp_next: got d=%h s=%0d want 22220000/2", res_data, res_src); end
    cnt_sel = 2'd2; tick();
    n_cmp++; if (cnt_value !== exp_cnt) begin n_err++; $display("FAIL cnt_src2: got %0d want %0d", cnt_value, exp_cnt); end
    cnt_sel = 2'd1; tick();
    n_cmp++; if (cnt_value !== 32'd0) begin n_err++; $display("FAIL cnt_src1: got %0d want 0", cnt_value); end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_sparse();
    test_full();
    test_drain();
    test_orphan();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
